reg_file_initializer: RTL and testbench
=======================================

# reg_file_initializer

Datapath core pairing a 16×16-bit register file with a combinational 16-bit ALU. Each clock, the ALU evaluates `opCode` on operand A = R[a_select] and operand B (register or immediate). The result is written into every register whose `regEnable` bit is set, and the status flags are updated. All sixteen registers and the flag register are exposed directly for the control unit and for debug.

## Interface
- No parameters. Data width fixed at 16, register count fixed at 16.
- clk  in  1  single system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- regEnable  in  16  one-hot or multi-hot write enables, one bit per register.
- immediate  in  16  immediate operand.
- use_imm  in  1  1 = operand B is `immediate`; 0 = operand B is R[b_select].
- opCode  in  8  ALU operation.
- a_select  in  4  operand A register index.
- b_select  in  4  operand B register index. Ignored when use_imm=1.
- r0..r15  out  16 each  current register contents.
- flags  out  5  registered status bits:
  - [4] Z zero
  - [3] C carry/borrow
  - [2] F signed overflow
  - [1] L low (A<B)
  - [0] N negative

## Operation
- B = use_imm ? immediate : R[b_select]. Immediate-form opcodes behave exactly like their register forms; only use_imm selects the operand.
- Arithmetic opcodes:
  - ADD 05/ADDI 50 and ADDU 06/ADDUI 60: A+B.
  - ADDC 07/ADDCI 70 and ADDCU 04/ADDCUI 40: A+B+flags[3], using the flag value registered before this cycle.
  - SUB 09/SUBI 90: A−B.
  - CMP 0B/CMPI B0: signed compare. CMPU 08/CMPUI 0C: unsigned compare.
- Logic opcodes: AND 01/ANDI 10: A&B. OR 02/ORI 20: A|B. XOR 03/XORI 30: A^B. NOT 0F: ~A, with B ignored.
- Shift opcodes use shift amount B[3:0]:
  - LSH 84/LSHI 80 and ALSH 86/ALSHI 82: A<<n.
  - RSH 85/RSHI 81: logical A>>n.
  - ARSH 87/ARSHI 83: arithmetic A>>>n.
- NOP 00 and all undefined opcodes produce result 0. They write nothing and leave flags unchanged.
- CMP-family opcodes update flags only. Register write is suppressed even when regEnable≠0.
- Arithmetic results wrap modulo 2^16.
- Flag updates:
  - Only the add, sub and cmp families update flags.
  - Logic, shift and NOT opcodes hold the flags.
  - Z = (result==0). For compares, Z = (A==B).
  - C: for adds, the unsigned carry-out of bit 15. For SUB/CMP, the unsigned borrow (A<B unsigned).
  - F = signed overflow of the add/sub. F=0 for compares.
  - L: for CMP/CMPI and SUB/SUBI, signed A<B. For CMPU/CMPUI, unsigned A<B. For adds, L=0.
  - N = result[15]. For compares, N = signed A<B.
- Multiple regEnable bits set: all selected registers receive the same result.
- a_select equal to a written register: the old value is used. This is a read-before-write at the edge.

## Timing
- Register reads and the ALU are purely combinational.
- Register and flag writes occur on the rising edge of clk.
- Results are visible on r0..r15 and flags one cycle after the operands are applied.
- reset low immediately forces all registers and flags to 0, regardless of clk. While reset is low, writes are blocked.
- Reset released mid-operation: the first edge after deassertion performs a normal write.

## Structure
- Shared package holds:
  - all opCode constants listed above;
  - flag index constants FLAG_Z=4, FLAG_C=3, FLAG_F=2, FLAG_L=1, FLAG_N=0.
- Sub-module `alu`: combinational. Inputs A, B, opCode, carry_in. Outputs result[15:0], flags_next[4:0], flag_we, reg_we.
- The top level contains the 16 register instances, the A/B muxes, and the flag register.

## Test plan
- Load via ORI then ANDI with immediate 0xBEEF into r5 -> r5=0xBEEF one cycle after the ANDI. Other registers are unchanged.
- r3=0x7FFF, r4=0x0001, ADD into r3 -> r3=0x8000, F=1, N=1, Z=0.
- r0=0xFFFF, ADDUI imm 2 -> r0=0x0001, C=1. Then r1=10, r2=20, ADDCU into r1 -> r1=31.
- r6=0xFFFE (−2), r7=3, CMP with regEnable=0x0040 -> L=1, Z=0, r6 unchanged. CMPI imm 0xFFFE -> Z=1.
- r8=0x8001, ARSHI imm 3 -> r8=0xF000. r9=0x0003, LSH by register holding 4 -> 0x0030. NOT of 0x00FF -> 0xFF00.
- Assert reset low mid-cycle after loads -> all r0..r15 and flags read 0 before the next clk edge.

Source files
------------

// File: rtl/reg_file_initializer_pkg.sv
// Shared opcode, flag index and ALU operation-class definitions
// for the 16x16 register file / ALU datapath.
package reg_file_initializer_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 16;
    localparam int FLAG_W = 5;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_AND    = 8'h01;
    localparam logic [7:0] OP_ANDI   = 8'h10;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_ORI    = 8'h20;
    localparam logic [7:0] OP_XOR    = 8'h03;
    localparam logic [7:0] OP_XORI   = 8'h30;
    localparam logic [7:0] OP_NOT    = 8'h0F;
    localparam logic [7:0] OP_ADD    = 8'h05;
    localparam logic [7:0] OP_ADDI   = 8'h50;
    localparam logic [7:0] OP_ADDU   = 8'h06;
    localparam logic [7:0] OP_ADDUI  = 8'h60;
    localparam logic [7:0] OP_ADDC   = 8'h07;
    localparam logic [7:0] OP_ADDCI  = 8'h70;
    localparam logic [7:0] OP_ADDCU  = 8'h04;
    localparam logic [7:0] OP_ADDCUI = 8'h40;
    localparam logic [7:0] OP_SUB    = 8'h09;
    localparam logic [7:0] OP_SUBI   = 8'h90;
    localparam logic [7:0] OP_CMP    = 8'h0B;
    localparam logic [7:0] OP_CMPI   = 8'hB0;
    localparam logic [7:0] OP_CMPU   = 8'h08;
    localparam logic [7:0] OP_CMPUI  = 8'h0C;
    localparam logic [7:0] OP_LSH    = 8'h84;
    localparam logic [7:0] OP_LSHI   = 8'h80;
    localparam logic [7:0] OP_ALSH   = 8'h86;
    localparam logic [7:0] OP_ALSHI  = 8'h82;
    localparam logic [7:0] OP_RSH    = 8'h85;
    localparam logic [7:0] OP_RSHI   = 8'h81;
    localparam logic [7:0] OP_ARSH   = 8'h87;
    localparam logic [7:0] OP_ARSHI  = 8'h83;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_ADDC,
        CLS_SUB,
        CLS_CMP,
        CLS_CMPU,
        CLS_AND,
        CLS_OR,
        CLS_XOR,
        CLS_NOT,
        CLS_LSH,
        CLS_RSH,
        CLS_ARSH
    } alu_class_e;

    // Register and immediate forms collapse onto one class.
    function automatic alu_class_e op_class(input logic [7:0] op);
        alu_class_e c;
        case (op)
            OP_ADD, OP_ADDI, OP_ADDU, OP_ADDUI:       c = CLS_ADD;
            OP_ADDC, OP_ADDCI, OP_ADDCU, OP_ADDCUI:   c = CLS_ADDC;
            OP_SUB, OP_SUBI:                          c = CLS_SUB;
            OP_CMP, OP_CMPI:                          c = CLS_CMP;
            OP_CMPU, OP_CMPUI:                        c = CLS_CMPU;
            OP_AND, OP_ANDI:                          c = CLS_AND;
            OP_OR, OP_ORI:                            c = CLS_OR;
            OP_XOR, OP_XORI:                          c = CLS_XOR;
            OP_NOT:                                   c = CLS_NOT;
            OP_LSH, OP_LSHI, OP_ALSH, OP_ALSHI:       c = CLS_LSH;
            OP_RSH, OP_RSHI:                          c = CLS_RSH;
            OP_ARSH, OP_ARSHI:                        c = CLS_ARSH;
            default:                                  c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_initializer_alu.sv
// Combinational 16-bit ALU: result, next flags and write strobes
// for register file and flag register.
module alu
    import reg_file_initializer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        op_code,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags_next,
    output logic              flag_we,
    output logic              reg_we
);

    alu_class_e      cls;
    logic            cin;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [3:0]      shamt;
    logic            slt;
    logic            ult;
    logic            add_ovf;
    logic            sub_ovf;

    assign cls   = op_class(op_code);
    assign cin   = (cls == CLS_ADDC) ? carry_in : 1'b0;
    assign sum   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[3:0];
    assign slt   = $signed(a) < $signed(b);
    assign ult   = a < b;

    // Overflow: operands agree (add) or differ (sub) in sign, result does not match A.
    assign add_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
    assign sub_ovf = (a[15] != b[15]) && (diff[15] != a[15]);

    always_comb begin
        result     = '0;
        flags_next = '0;
        flag_we    = 1'b0;
        reg_we     = 1'b0;
        unique case (cls)
            CLS_ADD, CLS_ADDC: begin
                result             = sum[DATA_W-1:0];
                reg_we             = 1'b1;
                flag_we            = 1'b1;
                flags_next[FLAG_Z] = (sum[DATA_W-1:0] == '0);
                flags_next[FLAG_C] = sum[DATA_W];
                flags_next[FLAG_F] = add_ovf;
                flags_next[FLAG_L] = 1'b0;
                flags_next[FLAG_N] = sum[15];
            end
            CLS_SUB: begin
                result             = diff[DATA_W-1:0];
                reg_we             = 1'b1;
                flag_we            = 1'b1;
                flags_next[FLAG_Z] = (diff[DATA_W-1:0] == '0);
                flags_next[FLAG_C] = ult;
                flags_next[FLAG_F] = sub_ovf;
                flags_next[FLAG_L] = slt;
                flags_next[FLAG_N] = diff[15];
            end
            CLS_CMP, CLS_CMPU: begin
                result             = diff[DATA_W-1:0];
                flag_we            = 1'b1;
                flags_next[FLAG_Z] = (a == b);
                flags_next[FLAG_C] = ult;
                flags_next[FLAG_F] = 1'b0;
                flags_next[FLAG_L] = (cls == CLS_CMPU) ? ult : slt;
                flags_next[FLAG_N] = slt;
            end
            CLS_AND: begin
                result = a & b;
                reg_we = 1'b1;
            end
            CLS_OR: begin
                result = a | b;
                reg_we = 1'b1;
            end
            CLS_XOR: begin
                result = a ^ b;
                reg_we = 1'b1;
            end
            CLS_NOT: begin
                result = ~a;
                reg_we = 1'b1;
            end
            CLS_LSH: begin
                result = a << shamt;
                reg_we = 1'b1;
            end
            CLS_RSH: begin
                result = a >> shamt;
                reg_we = 1'b1;
            end
            CLS_ARSH: begin
                result = $signed(a) >>> shamt;
                reg_we = 1'b1;
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_initializer.sv
// 16x16-bit register file around a combinational ALU, with a
// registered 5-bit status flag word and every register exposed.
module reg_file_initializer
    import reg_file_initializer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_N-1:0]    regEnable,
    input  logic [DATA_W-1:0]   immediate,
    input  logic                use_imm,
    input  logic [7:0]          opCode,
    input  logic [3:0]          a_select,
    input  logic [3:0]          b_select,
    output logic [DATA_W-1:0]   r0,
    output logic [DATA_W-1:0]   r1,
    output logic [DATA_W-1:0]   r2,
    output logic [DATA_W-1:0]   r3,
    output logic [DATA_W-1:0]   r4,
    output logic [DATA_W-1:0]   r5,
    output logic [DATA_W-1:0]   r6,
    output logic [DATA_W-1:0]   r7,
    output logic [DATA_W-1:0]   r8,
    output logic [DATA_W-1:0]   r9,
    output logic [DATA_W-1:0]   r10,
    output logic [DATA_W-1:0]   r11,
    output logic [DATA_W-1:0]   r12,
    output logic [DATA_W-1:0]   r13,
    output logic [DATA_W-1:0]   r14,
    output logic [DATA_W-1:0]   r15,
    output logic [FLAG_W-1:0]   flags
);

    logic [DATA_W-1:0] rf [REG_N];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags_next;
    logic [FLAG_W-1:0] flags_q;
    logic              flag_we;
    logic              reg_we;

    assign op_a = rf[a_select];
    assign op_b = use_imm ? immediate : rf[b_select];

    alu u_alu (
        .a          (op_a),
        .b          (op_b),
        .op_code    (opCode),
        .carry_in   (flags_q[FLAG_C]),
        .result     (result),
        .flags_next (flags_next),
        .flag_we    (flag_we),
        .reg_we     (reg_we)
    );

    // Operands are sampled before the edge, so a register may be both source and target.
    for (genvar i = 0; i < REG_N; i++) begin : g_reg
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q <= '0;
            end else if (reg_we && regEnable[i]) begin
                q <= result;
            end
        end
        assign rf[i] = q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= flags_next;
        end
    end

    assign flags = flags_q;

    assign r0  = rf[0];
    assign r1  = rf[1];
    assign r2  = rf[2];
    assign r3  = rf[3];
    assign r4  = rf[4];
    assign r5  = rf[5];
    assign r6  = rf[6];
    assign r7  = rf[7];
    assign r8  = rf[8];
    assign r9  = rf[9];
    assign r10 = rf[10];
    assign r11 = rf[11];
    assign r12 = rf[12];
    assign r13 = rf[13];
    assign r14 = rf[14];
    assign r15 = rf[15];

endmodule

// File: tb/tb_reg_file_initializer.sv
// Directed self-checking bench for reg_file_initializer.
module tb_reg_file_initializer;

    localparam logic [7:0] NOP   = 8'h00;
    localparam logic [7:0] ANDI  = 8'h10;
    localparam logic [7:0] ORI   = 8'h20;
    localparam logic [7:0] NOT_  = 8'h0F;
    localparam logic [7:0] ADD   = 8'h05;
    localparam logic [7:0] ADDI  = 8'h50;
    localparam logic [7:0] ADDUI = 8'h60;
    localparam logic [7:0] ADDCU = 8'h04;
    localparam logic [7:0] SUB   = 8'h09;
    localparam logic [7:0] CMP   = 8'h0B;
    localparam logic [7:0] CMPI  = 8'hB0;
    localparam logic [7:0] CMPU  = 8'h08;
    localparam logic [7:0] LSH   = 8'h84;
    localparam logic [7:0] ARSHI = 8'h83;
    localparam logic [7:0] UNDEF = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] regEnable = '0;
    logic [15:0] immediate = '0;
    logic        use_imm = 1'b0;
    logic [7:0]  opCode = '0;
    logic [3:0]  a_select = '0;
    logic [3:0]  b_select = '0;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
    logic [4:0]  flags;
    logic [15:0] rr [16];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_initializer dut (
        .clk       (clk),
        .reset     (reset),
        .regEnable (regEnable),
        .immediate (immediate),
        .use_imm   (use_imm),
        .opCode    (opCode),
        .a_select  (a_select),
        .b_select  (b_select),
        .r0 (r0),   .r1 (r1),   .r2 (r2),   .r3 (r3),
        .r4 (r4),   .r5 (r5),   .r6 (r6),   .r7 (r7),
        .r8 (r8),   .r9 (r9),   .r10 (r10), .r11 (r11),
        .r12 (r12), .r13 (r13), .r14 (r14), .r15 (r15),
        .flags     (flags)
    );

    assign rr = '{r0, r1, r2, r3, r4, r5, r6, r7,
                  r8, r9, r10, r11, r12, r13, r14, r15};

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] en, input logic [7:0] op,
                        input logic [3:0] as, input logic [3:0] bs,
                        input logic ui, input logic [15:0] imm);
        regEnable = en;
        opCode    = op;
        a_select  = as;
        b_select  = bs;
        use_imm   = ui;
        immediate = imm;
        @(posedge clk);
        #1;
        regEnable = '0;
        opCode    = NOP;
    endtask

    // r15 is never written, so OR with it loads an immediate.
    task automatic load(input int idx, input logic [15:0] v);
        step(16'(1 << idx), ORI, 4'd15, 4'd0, 1'b1, v);
    endtask

    initial begin
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), rr[i], 16'h0);
        chk("rst_flags", {11'b0, flags}, 16'h0);
        #12 reset = 1'b1;
        @(posedge clk);
        #1;

        step(16'h0020, ORI, 4'd5, 4'd0, 1'b1, 16'hBEEF);
        step(16'h0020, ANDI, 4'd5, 4'd0, 1'b1, 16'hBEEF);
        chk("andi_r5", r5, 16'hBEEF);
        chk("andi_r4", r4, 16'h0);
        chk("andi_flags", {11'b0, flags}, 16'h0);

        load(3, 16'h7FFF);
        load(4, 16'h0001);
        step(16'h0008, ADD, 4'd3, 4'd4, 1'b0, 16'h0);
        chk("add_r3", r3, 16'h8000);
        chk("add_flags", {11'b0, flags}, 16'h0005);

        load(0, 16'hFFFF);
        step(16'h0001, ADDUI, 4'd0, 4'd0, 1'b1, 16'h0002);
        chk("addui_r0", r0, 16'h0001);
        chk("addui_flags", {11'b0, flags}, 16'h0008);
        load(1, 16'd10);
        load(2, 16'd20);
        chk("logic_hold_flags", {11'b0, flags}, 16'h0008);
        step(16'h0002, ADDCU, 4'd1, 4'd2, 1'b0, 16'h0);
        chk("addcu_r1", r1, 16'd31);
        chk("addcu_flags", {11'b0, flags}, 16'h0);

        load(6, 16'hFFFE);
        load(7, 16'h0003);
        step(16'h0040, CMP, 4'd6, 4'd7, 1'b0, 16'h0);
        chk("cmp_flags", {11'b0, flags}, 16'h0003);
        chk("cmp_r6", r6, 16'hFFFE);
        step(16'h0040, CMPI, 4'd6, 4'd0, 1'b1, 16'hFFFE);
        chk("cmpi_flags", {11'b0, flags}, 16'h0010);
        step(16'h0040, CMPU, 4'd6, 4'd7, 1'b0, 16'h0);
        chk("cmpu_ge_flags", {11'b0, flags}, 16'h0001);
        step(16'h0080, CMPU, 4'd7, 4'd6, 1'b0, 16'h0);
        chk("cmpu_lt_flags", {11'b0, flags}, 16'h000A);
        chk("cmpu_r7", r7, 16'h0003);

        load(8, 16'h8001);
        step(16'h0100, ARSHI, 4'd8, 4'd0, 1'b1, 16'h0003);
        chk("arshi_r8", r8, 16'hF000);
        load(9, 16'h0003);
        load(10, 16'h0004);
        step(16'h0200, LSH, 4'd9, 4'd10, 1'b0, 16'h0);
        chk("lsh_r9", r9, 16'h0030);
        load(11, 16'h00FF);
        step(16'h0800, NOT_, 4'd11, 4'd3, 1'b0, 16'h0);
        chk("not_r11", r11, 16'hFF00);
        chk("shift_hold_flags", {11'b0, flags}, 16'h000A);

        step(16'hFFFF, NOP, 4'd5, 4'd5, 1'b0, 16'h0);
        chk("nop_r5", r5, 16'hBEEF);
        step(16'hFFFF, UNDEF, 4'd5, 4'd5, 1'b1, 16'h1234);
        chk("undef_r11", r11, 16'hFF00);
        chk("undef_flags", {11'b0, flags}, 16'h000A);

        load(12, 16'd5);
        load(13, 16'd7);
        step(16'h1000, SUB, 4'd12, 4'd13, 1'b0, 16'h0);
        chk("sub_r12", r12, 16'hFFFE);
        chk("sub_flags", {11'b0, flags}, 16'h000B);

        step(16'h6000, ORI, 4'd15, 4'd0, 1'b1, 16'h1234);
        chk("multi_r13", r13, 16'h1234);
        chk("multi_r14", r14, 16'h1234);

        step(16'h0020, ADDI, 4'd5, 4'd0, 1'b1, 16'h0001);
        chk("rbw_r5", r5, 16'hBEF0);
        chk("addi_flags", {11'b0, flags}, 16'h0001);

        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("midrst_r%0d", i), rr[i], 16'h0);
        chk("midrst_flags", {11'b0, flags}, 16'h0);
        regEnable = 16'hFFFF;
        opCode    = ORI;
        a_select  = 4'd15;
        use_imm   = 1'b1;
        immediate = 16'h5555;
        @(posedge clk);
        #1;
        chk("rst_blocks_write", r3, 16'h0);
        regEnable = '0;
        opCode    = NOP;
        #2 reset = 1'b1;
        step(16'h0004, ORI, 4'd15, 4'd0, 1'b1, 16'h00AA);
        chk("post_rst_r2", r2, 16'h00AA);
        chk("post_rst_r3", r3, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
